// File: rtl/log2_fix.sv
// log2 front-end for bfloat16: unbiased exponent as integer part, fraction computed
// one bit per cycle by repeated squaring of the significand; special operands flagged.
module log2_fix #(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned MAN_WIDTH  = 7,
    parameter int unsigned WORK_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_log2_i,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   operando,
    output logic                           ready_o,
    output logic [EXP_WIDTH-1:0]           parte_intera,
    output logic [MAN_WIDTH-1:0]           parte_frazionaria,
    output logic                           valid_log2_o,
    output logic                           zero_o,
    output logic                           inf_o,
    output logic                           nan_o
);

    localparam int unsigned CNT_WIDTH = (MAN_WIDTH > 1) ? $clog2(MAN_WIDTH) : 1;
    localparam int unsigned PAD_WIDTH = WORK_WIDTH - MAN_WIDTH - 1;
    localparam logic [EXP_WIDTH-1:0] EXP_BIAS = {1'b0, {(EXP_WIDTH-1){1'b1}}};
    localparam logic [CNT_WIDTH-1:0] K_START  = CNT_WIDTH'(MAN_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e                  state_q, state_d;
    logic [WORK_WIDTH-1:0]   y_q, y_d;
    logic [CNT_WIDTH-1:0]    k_q, k_d;
    logic [MAN_WIDTH-1:0]    frac_acc_q, frac_acc_d;
    logic [EXP_WIDTH-1:0]    int_acc_q, int_acc_d;
    logic [EXP_WIDTH-1:0]    int_q, int_d;
    logic [MAN_WIDTH-1:0]    frac_q, frac_d;
    logic                    valid_q, valid_d;
    logic                    zero_q, zero_d;
    logic                    inf_q, inf_d;
    logic                    nan_q, nan_d;

    logic                    op_sign;
    logic [EXP_WIDTH-1:0]    op_exp;
    logic [MAN_WIDTH-1:0]    op_man;
    logic                    exp_zero;
    logic                    exp_ones;
    logic                    man_nz;
    logic                    op_special;

    logic [2*WORK_WIDTH-1:0] square;
    logic                    sq_msb;
    logic [WORK_WIDTH-1:0]   y_norm;
    logic [MAN_WIDTH-1:0]    frac_bits;
    logic                    unused_sq_lsbs;

    assign op_sign    = operando[EXP_WIDTH+MAN_WIDTH];
    assign op_exp     = operando[EXP_WIDTH+MAN_WIDTH-1:MAN_WIDTH];
    assign op_man     = operando[MAN_WIDTH-1:0];
    assign exp_zero   = (op_exp == '0);
    assign exp_ones   = &op_exp;
    assign man_nz     = |op_man;
    assign op_special = exp_zero | exp_ones | op_sign;

    // y is Q1.(W-1) in [1,2), so y*y is Q2.(2W-2) in [1,4); renormalise back into [1,2).
    assign square    = {{WORK_WIDTH{1'b0}}, y_q} * {{WORK_WIDTH{1'b0}}, y_q};
    assign sq_msb    = square[2*WORK_WIDTH-1];
    assign y_norm    = sq_msb ? square[2*WORK_WIDTH-1:WORK_WIDTH]
                              : square[2*WORK_WIDTH-2:WORK_WIDTH-1];
    assign frac_bits = {frac_acc_q[MAN_WIDTH-2:0], sq_msb};
    assign unused_sq_lsbs = ^square[WORK_WIDTH-2:0];

    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        k_d        = k_q;
        frac_acc_d = frac_acc_q;
        int_acc_d  = int_acc_q;
        int_d      = int_q;
        frac_d     = frac_q;
        valid_d    = 1'b0;
        zero_d     = zero_q;
        inf_d      = inf_q;
        nan_d      = nan_q;

        unique case (state_q)
            StIdle: begin
                if (valid_log2_i) begin
                    if (op_special) begin
                        state_d = StDone;
                        valid_d = 1'b1;
                        int_d   = '0;
                        frac_d  = '0;
                        zero_d  = exp_zero;
                        nan_d   = !exp_zero && ((exp_ones && man_nz) || op_sign);
                        inf_d   = !exp_zero && exp_ones && !man_nz && !op_sign;
                    end else begin
                        state_d    = StIter;
                        int_acc_d  = op_exp - EXP_BIAS;
                        y_d        = {1'b1, op_man, {PAD_WIDTH{1'b0}}};
                        k_d        = K_START;
                        frac_acc_d = '0;
                    end
                end
            end
            StIter: begin
                y_d        = y_norm;
                frac_acc_d = frac_bits;
                if (k_q == '0) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                    int_d   = int_acc_q;
                    frac_d  = frac_bits;
                    zero_d  = 1'b0;
                    inf_d   = 1'b0;
                    nan_d   = 1'b0;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            y_q        <= '0;
            k_q        <= '0;
            frac_acc_q <= '0;
            int_acc_q  <= '0;
            int_q      <= '0;
            frac_q     <= '0;
            valid_q    <= 1'b0;
            zero_q     <= 1'b0;
            inf_q      <= 1'b0;
            nan_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            k_q        <= k_d;
            frac_acc_q <= frac_acc_d;
            int_acc_q  <= int_acc_d;
            int_q      <= int_d;
            frac_q     <= frac_d;
            valid_q    <= valid_d;
            zero_q     <= zero_d;
            inf_q      <= inf_d;
            nan_q      <= nan_d;
        end
    end

    assign ready_o           = (state_q == StIdle);
    assign parte_intera      = int_q;
    assign parte_frazionaria = frac_q;
    assign valid_log2_o      = valid_q;
    assign zero_o            = zero_q;
    assign inf_o             = inf_q;
    assign nan_o             = nan_q;

endmodule
